// File: rtl/sine_rom_reader_if.sv
// sine_rom_reader_if: bundles the ROM read port and the sample stream of sine_rom_reader.
//   Parameters: WIDTH (ROM word / sample width), AW (ROM address width).
//   ROM side   : rom_en, rom_address (reader -> ROM), rom_data (ROM -> reader, registered).
//   Stream side: s_data, s_valid (reader -> consumer), s_ready (consumer -> reader).
//   modport master: the reader. modport slave: the ROM plus the sample consumer.
interface sine_rom_reader_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 6
);
  logic             rom_en;
  logic [AW-1:0]    rom_address;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (
    output rom_en, rom_address, s_data, s_valid,
    input  rom_data, s_ready
  );

  modport slave (
    input  rom_en, rom_address, s_data, s_valid,
    output rom_data, s_ready
  );
endinterface

// File: rtl/sine_rom_reader.sv
// sine_rom_reader: phase-accumulator sequencer for a synchronous sine lookup ROM.
//   Each sample walks IDLE/READ -> WAIT -> VALID: a ROM read is issued in READ at the address
//   taken from the phase accumulator, the registered ROM word is captured in WAIT, and the
//   sample is held in VALID until the consumer accepts it.
// Ports:
//   clk  : clock, rising edge.
//   rst  : asynchronous active-high reset.
//   run  : level enable; sampled in IDLE and at the VALID transfer.
//   fcw  : phase increment, applied at each READ.
//   bus  : sine_rom_reader_if.master (ROM read port + valid/ready sample stream).
// Build option: define SINE_QUARTER_WAVE_EN for a quarter-period ROM of unsigned magnitudes
//   (address mirroring and sign restoration); otherwise the ROM holds a full signed period.
module sine_rom_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [ACC_W-1:0]   fcw,
  sine_rom_reader_if.master  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRead, StWait, StValid} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] phase_q;
  logic             rom_en_q;
  logic [AW-1:0]    rom_addr_q;
  logic [WIDTH-1:0] s_data_q;
  logic [AW-1:0]    addr_next;
  logic [WIDTH-1:0] mapped;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run) state_d = StRead;
      StRead:  state_d = StWait;
      StWait:  state_d = StValid;
      StValid: if (bus.s_ready) state_d = run ? StRead : StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef SINE_QUARTER_WAVE_EN
  // Only the sign half of the quadrant is needed once READ has chosen the address.
  logic          quad_hi_q;
  logic [1:0]    quad_cur;
  logic [AW-1:0] idx;

  assign quad_cur = phase_q[ACC_W-1 -: 2];
  assign idx      = phase_q[ACC_W-3 -: AW];
  // Odd quadrants run the table backwards; ~idx gives DEPTH-1..0 exactly.
  assign addr_next = quad_cur[0] ? ~idx : idx;
  assign mapped    = quad_hi_q ? (WIDTH'(0) - bus.rom_data) : bus.rom_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quad_hi_q <= 1'b0;
    end else if (state_q == StRead) begin
      quad_hi_q <= quad_cur[1];
    end
  end
`else
  assign addr_next = phase_q[ACC_W-1 -: AW];
  assign mapped    = bus.rom_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      s_data_q   <= '0;
    end else begin
      state_q <= state_d;
      // Address/enable are registered on entry to READ. phase_q only moves at the READ edge,
      // so the value seen here is the one READ is meant to use.
      rom_en_q   <= (state_d == StRead);
      rom_addr_q <= (state_d == StRead) ? addr_next : '0;
      if (state_q == StRead) phase_q  <= phase_q + fcw;
      if (state_q == StWait) s_data_q <= mapped;
    end
  end

  assign bus.rom_en      = rom_en_q;
  assign bus.rom_address = rom_addr_q;
  assign bus.s_data      = s_data_q;
  assign bus.s_valid     = (state_q == StValid);

endmodule
